// File: rtl/io_write_master.sv
// Buffered write master: queues source words in a small FIFO and hands each one to an
// IO bridge over a four-phase ReqW/AckW handshake, with a per-phase timeout that locks into ERR.
module io_write_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          Valid_i,
  input  logic [DATA_WIDTH-1:0]         Data_i,
  output logic                          Ready_o,
  output logic                          ReqW_o,
  output logic [DATA_WIDTH-1:0]         Data_o,
  input  logic                          AckW_i,
  output logic [$clog2(FIFO_DEPTH):0]   Count_o,
  output logic                          Busy_o,
  output logic                          Timeout_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PTR_W:0]   DEPTH    = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_REL, ERR} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [TMR_W-1:0]        timer;
  logic                    push;
  logic                    pop;

  assign Ready_o = (Count_o < DEPTH) && (state != ERR);
  assign push    = Valid_i && Ready_o;
  assign Busy_o  = (state != IDLE) || (Count_o != '0);

  // A pop is decided from the pre-edge count, so a word pushed on the same edge is never popped.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    pop = 1'b0;
    case (state)
      IDLE:     pop = (Count_o != '0);
      WAIT_REL: pop = !AckW_i && (Count_o != '0);
      default:  pop = 1'b0;
    endcase
  end

  // NOTE: storage array carries no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= Data_i;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ReqW_o    <= 1'b0;
      Data_o    <= '0;
      Count_o   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      timer     <= '0;
      Timeout_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        Data_o <= mem[rd_ptr];
      end

      case ({push, pop})
        2'b10:   Count_o <= Count_o + 1'b1;
        2'b01:   Count_o <= Count_o - 1'b1;
        default: Count_o <= Count_o;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            state  <= REQ;
            ReqW_o <= 1'b1;
            timer  <= '0;
          end
        end
        REQ: begin
          // A qualifying ack on the expiry edge wins over the timeout.
          if (AckW_i) begin
            state  <= WAIT_REL;
            ReqW_o <= 1'b0;
            timer  <= '0;
          end else if (timer == TMR_LAST) begin
            state     <= ERR;
            ReqW_o    <= 1'b0;
            Timeout_o <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!AckW_i) begin
            timer <= '0;
            if (pop) begin
              state  <= REQ;
              ReqW_o <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (timer == TMR_LAST) begin
            state     <= ERR;
            Timeout_o <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ERR: begin
          ReqW_o    <= 1'b0;
          Timeout_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_write_master.sv
// Bench for io_write_master: a short-timeout instance for timeout behaviour and a long-timeout
// instance for buffering, mid-handshake reset and a long randomized run against a queue model.
module tb_io_write_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] data;

  logic       valid_s, ack_s, ready_s, reqw_s, busy_s, timeout_s;
  logic [7:0] dout_s;
  logic [2:0] count_s;

  logic       valid_l, ack_l, ready_l, reqw_l, busy_l, timeout_l;
  logic [7:0] dout_l;
  logic [2:0] count_l;

  int checks = 0;
  int errors = 0;

  io_write_master #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(3)) u_short (
    .clk(clk), .reset(reset), .Valid_i(valid_s), .Data_i(data), .Ready_o(ready_s),
    .ReqW_o(reqw_s), .Data_o(dout_s), .AckW_i(ack_s), .Count_o(count_s),
    .Busy_o(busy_s), .Timeout_o(timeout_s)
  );

  io_write_master #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(255)) u_long (
    .clk(clk), .reset(reset), .Valid_i(valid_l), .Data_i(data), .Ready_o(ready_l),
    .ReqW_o(reqw_l), .Data_o(dout_l), .AckW_i(ack_l), .Count_o(count_l),
    .Busy_o(busy_l), .Timeout_o(timeout_l)
  );

  // Advance one rising edge and park on the falling edge, where outputs are sampled and inputs driven.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    valid_s = 1'b0; ack_s = 1'b0; valid_l = 1'b0; ack_l = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    valid_s = 1'b0; ack_s = 1'b0; valid_l = 1'b0; ack_l = 1'b0; data = 8'h00;
    reset = 1'b0;
    step();
    checks++; if (reqw_s !== 1'b0)    begin errors++; $display("FAIL reset_reqw: got %0h want 0", reqw_s); end
    checks++; if (dout_s !== 8'h00)   begin errors++; $display("FAIL reset_data: got %0h want 0", dout_s); end
    checks++; if (count_s !== 3'd0)   begin errors++; $display("FAIL reset_count: got %0d want 0", count_s); end
    checks++; if (ready_s !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %0h want 1", ready_s); end
    checks++; if (timeout_s !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0h want 0", timeout_s); end
    checks++; if (busy_s !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %0h want 0", busy_s); end
    checks++; if (ready_l !== 1'b1)   begin errors++; $display("FAIL reset_ready_long: got %0h want 1", ready_l); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    int n;
    apply_reset();
    valid_s = 1'b1; data = 8'h11;
    step();
    valid_s = 1'b0;
    checks++; if (count_s !== 3'd1) begin errors++; $display("FAIL single_count_e0: got %0d want 1", count_s); end
    checks++; if (reqw_s !== 1'b0)  begin errors++; $display("FAIL single_reqw_e0: got %0h want 0", reqw_s); end
    step();
    checks++; if (reqw_s !== 1'b1)  begin errors++; $display("FAIL single_reqw_e1: got %0h want 1", reqw_s); end
    checks++; if (dout_s !== 8'h11) begin errors++; $display("FAIL single_data: got %0h want 11", dout_s); end
    checks++; if (count_s !== 3'd0) begin errors++; $display("FAIL single_count_e1: got %0d want 0", count_s); end
    n = 0;
    while ((busy_s || reqw_s || ack_s) && n < 10) begin
      if (reqw_s) begin
        checks++; if (dout_s !== 8'h11) begin errors++; $display("FAIL single_hold: got %0h want 11", dout_s); end
      end
      ack_s = reqw_s;
      step();
      n++;
    end
    checks++; if (n >= 10)           begin errors++; $display("FAIL single_done: got busy after %0d cycles want idle", n); end
    checks++; if (timeout_s !== 1'b0) begin errors++; $display("FAIL single_timeout: got %0h want 0", timeout_s); end
  endtask

  task automatic test_fill();
    logic [7:0] want [5];
    logic [7:0] got [$];
    logic       prev;
    int         n;
    want[0] = 8'h9F; want[1] = 8'hA0; want[2] = 8'hA1; want[3] = 8'hA2; want[4] = 8'hA3;
    apply_reset();
    valid_l = 1'b1; data = 8'h9F;
    step();
    valid_l = 1'b0;
    step();
    checks++; if (reqw_l !== 1'b1) begin errors++; $display("FAIL fill_prime_req: got %0h want 1", reqw_l); end
    for (int i = 0; i < 6; i++) begin
      data = 8'hA0 + 8'(i);
      valid_l = 1'b1;
      checks++; if (ready_l !== (i < 4)) begin errors++; $display("FAIL fill_ready_%0d: got %0h want %0h", i, ready_l, (i < 4)); end
      step();
    end
    valid_l = 1'b0;
    checks++; if (count_l !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", count_l); end
    checks++; if (ready_l !== 1'b0) begin errors++; $display("FAIL fill_ready_full: got %0h want 0", ready_l); end
    prev = 1'b0;
    n = 0;
    while (got.size() < 5 && n < 40) begin
      if (reqw_l && !prev) got.push_back(dout_l);
      prev  = reqw_l;
      ack_l = reqw_l;
      step();
      n++;
    end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL fill_delivered: got %0d words want 5", got.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) begin
        checks++; if (got[i] !== want[i]) begin errors++; $display("FAIL fill_order_%0d: got %0h want %0h", i, got[i], want[i]); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      ack_l = reqw_l;
      step();
    end
    checks++; if (busy_l !== 1'b0) begin errors++; $display("FAIL fill_idle: got busy %0h want 0", busy_l); end
  endtask

  task automatic test_timeout();
    apply_reset();
    valid_s = 1'b1; data = 8'h5A;
    step();
    valid_s = 1'b0;
    step();
    checks++; if (reqw_s !== 1'b1) begin errors++; $display("FAIL to_req: got %0h want 1", reqw_s); end
    step();
    step();
    checks++; if (timeout_s !== 1'b0) begin errors++; $display("FAIL to_early: got %0h want 0", timeout_s); end
    checks++; if (reqw_s !== 1'b1)    begin errors++; $display("FAIL to_early_req: got %0h want 1", reqw_s); end
    step();
    checks++; if (timeout_s !== 1'b1) begin errors++; $display("FAIL to_flag: got %0h want 1", timeout_s); end
    checks++; if (reqw_s !== 1'b0)    begin errors++; $display("FAIL to_reqw: got %0h want 0", reqw_s); end
    checks++; if (ready_s !== 1'b0)   begin errors++; $display("FAIL to_ready: got %0h want 0", ready_s); end
    checks++; if (busy_s !== 1'b1)    begin errors++; $display("FAIL to_busy: got %0h want 1", busy_s); end
    valid_s = 1'b1; data = 8'h77;
    for (int i = 0; i < 4; i++) begin
      ack_s = i[0];
      step();
      checks++; if (ready_s !== 1'b0)   begin errors++; $display("FAIL err_ready_%0d: got %0h want 0", i, ready_s); end
      checks++; if (timeout_s !== 1'b1) begin errors++; $display("FAIL err_sticky_%0d: got %0h want 1", i, timeout_s); end
      checks++; if (count_s !== 3'd0)   begin errors++; $display("FAIL err_count_%0d: got %0d want 0", i, count_s); end
      checks++; if (reqw_s !== 1'b0)    begin errors++; $display("FAIL err_reqw_%0d: got %0h want 0", i, reqw_s); end
      checks++; if (dout_s !== 8'h5A)   begin errors++; $display("FAIL err_data_%0d: got %0h want 5a", i, dout_s); end
    end
    apply_reset();
    checks++; if (timeout_s !== 1'b0) begin errors++; $display("FAIL to_cleared: got %0h want 0", timeout_s); end
    checks++; if (ready_s !== 1'b1)   begin errors++; $display("FAIL to_ready_back: got %0h want 1", ready_s); end
  endtask

  task automatic test_ack_race();
    apply_reset();
    valid_s = 1'b1; data = 8'h3C;
    step();
    valid_s = 1'b0;
    step();
    step();
    step();
    ack_s = 1'b1;
    step();
    checks++; if (reqw_s !== 1'b0)    begin errors++; $display("FAIL race_reqw: got %0h want 0", reqw_s); end
    checks++; if (timeout_s !== 1'b0) begin errors++; $display("FAIL race_timeout: got %0h want 0", timeout_s); end
    checks++; if (busy_s !== 1'b1)    begin errors++; $display("FAIL race_busy: got %0h want 1", busy_s); end
    ack_s = 1'b0;
    step();
    checks++; if (busy_s !== 1'b0)    begin errors++; $display("FAIL race_idle: got %0h want 0", busy_s); end
    ack_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (reqw_s !== 1'b0 || busy_s !== 1'b0) begin
        errors++; $display("FAIL idle_ack_%0d: got reqw %0h busy %0h want 0 0", i, reqw_s, busy_s);
      end
    end
    ack_s = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      valid_l = 1'b1; data = 8'hC0 + 8'(i);
      step();
    end
    valid_l = 1'b0;
    checks++; if (reqw_l !== 1'b1)  begin errors++; $display("FAIL mid_req: got %0h want 1", reqw_l); end
    checks++; if (count_l !== 3'd3) begin errors++; $display("FAIL mid_count: got %0d want 3", count_l); end
    reset = 1'b0;
    step();
    checks++; if (reqw_l !== 1'b0)  begin errors++; $display("FAIL mid_rst_reqw: got %0h want 0", reqw_l); end
    checks++; if (count_l !== 3'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", count_l); end
    checks++; if (ready_l !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %0h want 1", ready_l); end
    checks++; if (busy_l !== 1'b0)  begin errors++; $display("FAIL mid_rst_busy: got %0h want 0", busy_l); end
    reset = 1'b1;
    step();
    step();
    checks++; if (reqw_l !== 1'b0 || busy_l !== 1'b0) begin
      errors++; $display("FAIL mid_discard: got reqw %0h busy %0h want 0 0", reqw_l, busy_l);
    end
  endtask

  // Source offers random words; the bridge model acks each phase after 0..5 cycles.
  task automatic test_random();
    logic [7:0] exp_q [$];
    logic [7:0] exp_w;
    logic [7:0] last_w;
    logic       prev_req;
    int         ack_wait;
    int         delivered;
    int         cyc;
    apply_reset();
    prev_req = 1'b0; last_w = 8'h00; ack_wait = 0; delivered = 0; cyc = 0;
    while (cyc < 50200 && (cyc < 50000 || exp_q.size() != 0 || busy_l || ack_l)) begin
      if (reqw_l && !prev_req) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious: got word %0h want none", dout_l);
        end else begin
          exp_w = exp_q.pop_front();
          if (dout_l !== exp_w) begin errors++; $display("FAIL rand_word: got %0h want %0h", dout_l, exp_w); end
        end
        last_w = dout_l;
        delivered++;
      end else if (reqw_l) begin
        checks++; if (dout_l !== last_w) begin errors++; $display("FAIL rand_stable: got %0h want %0h", dout_l, last_w); end
      end
      prev_req = reqw_l;
      checks++; if (count_l !== 3'(exp_q.size())) begin errors++; $display("FAIL rand_count: got %0d want %0d", count_l, exp_q.size()); end
      checks++; if (ready_l !== (exp_q.size() < 4)) begin errors++; $display("FAIL rand_ready: got %0h want %0h", ready_l, (exp_q.size() < 4)); end
      if (ack_l != reqw_l) begin
        if (ack_wait == 0) begin
          ack_l = reqw_l;
          ack_wait = $urandom_range(0, 5);
        end else begin
          ack_wait--;
        end
      end
      valid_l = (cyc < 50000) && ($urandom_range(0, 99) < 60);
      data = 8'($urandom);
      if (valid_l && ready_l) exp_q.push_back(data);
      step();
      cyc++;
    end
    valid_l = 1'b0;
    checks++; if (exp_q.size() != 0)  begin errors++; $display("FAIL rand_drain: got %0d left want 0", exp_q.size()); end
    checks++; if (busy_l !== 1'b0)    begin errors++; $display("FAIL rand_idle: got %0h want 0", busy_l); end
    checks++; if (timeout_l !== 1'b0) begin errors++; $display("FAIL rand_timeout: got %0h want 0", timeout_l); end
    checks++; if (delivered < 1000)   begin errors++; $display("FAIL rand_volume: got %0d words want >= 1000", delivered); end
  endtask

  initial begin
    reset = 1'b0; data = 8'h00;
    valid_s = 1'b0; ack_s = 1'b0; valid_l = 1'b0; ack_l = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_timeout();
    test_ack_race();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_write_master.md
IO_WRITE_MASTER -- requirements
Module: io_write_master

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of every data word.
REQ-002 Parameter FIFO_DEPTH, default 4: input buffer entries; SHALL be a power of 2, minimum 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum cycles spent waiting on any one ack edge; minimum 1.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 Valid_i  in  1  source offers Data_i this cycle.
REQ-007 Data_i  in  DATA_WIDTH  source word.
REQ-008 Ready_o  out  1  block accepts Data_i this cycle.
REQ-009 ReqW_o  out  1  write request to the downstream IO bridge (its ReqW_i).
REQ-010 Data_o  out  DATA_WIDTH  word presented to the bridge (its Data_i).
REQ-011 AckW_i  in  1  write acknowledge from the bridge (its AckW_o).
REQ-012 Count_o  out  clog2(FIFO_DEPTH)+1  words currently buffered.
REQ-013 Busy_o  out  1  high when state is not IDLE or Count_o is non-zero.
REQ-014 Timeout_o  out  1  sticky handshake-timeout flag.

Function
REQ-015 Accept: a word SHALL be pushed on a rising edge where Valid_i=1 and Ready_o=1.
REQ-016 Ready_o SHALL be combinational: 1 when Count_o < FIFO_DEPTH and state is not ERR; no full-FIFO bypass.
REQ-017 Simultaneous push and pop on one edge SHALL leave Count_o unchanged and preserve FIFO order; pointers wrap modulo FIFO_DEPTH.
REQ-018 States: IDLE, REQ, WAIT_REL, ERR; four-phase handshake towards the bridge.
REQ-019 IDLE: if Count_o > 0, pop head into Data_o, set ReqW_o=1, go to REQ; otherwise stay.
REQ-020 REQ: hold ReqW_o=1 and Data_o constant; on an edge with AckW_i=1, set ReqW_o=0 and go to WAIT_REL.
REQ-021 WAIT_REL: ReqW_o=0; on an edge with AckW_i=0, pop and re-enter REQ if Count_o > 0, else go to IDLE.
REQ-022 Latency: word accepted at edge E0 into an empty, idle block SHALL produce ReqW_o=1 after edge E1; minimum sustained rate one word per 2 cycles.
REQ-023 Timer SHALL clear on every entry to REQ or WAIT_REL and increment each cycle in that state.
REQ-024 If the exit condition of REQ or WAIT_REL is unmet for TIMEOUT_CYCLES consecutive edges, go to ERR; a qualifying AckW_i on the final edge SHALL take priority over timeout.
REQ-025 ERR: ReqW_o=0, Timeout_o=1, Ready_o=0, FIFO contents held; leaves only via reset.
REQ-026 Data_o SHALL change only on a pop; it holds its last value otherwise.
REQ-027 AckW_i=1 while in IDLE SHALL be ignored.

Reset
REQ-028 While reset=0 at an edge: state IDLE, ReqW_o=0, Data_o=0, Count_o=0, FIFO pointers 0, timer 0, Timeout_o=0; Ready_o=1 after that edge.
REQ-029 Reset mid-handshake SHALL drop ReqW_o after that edge and discard all buffered words.

Verification
REQ-030 Reset, then push 0x11 with AckW_i tied to ReqW_o delayed by one cycle -> ReqW_o rises one edge after acceptance, Data_o=0x11 while ReqW_o=1, Count_o returns to 0.
REQ-031 Push 0xA0..0xA5 with AckW_i held 0 -> Ready_o low after 4 accepted words (Count_o=4); 0xA4 and 0xA5 not accepted; the following acks deliver 0xA0..0xA3 in order.
REQ-032 Hold AckW_i=0 for TIMEOUT_CYCLES=3 after a request -> ERR on the 3rd edge, Timeout_o=1, ReqW_o=0, Ready_o=0 until reset.
REQ-033 AckW_i rises on the same edge the timer expires -> WAIT_REL entered, Timeout_o stays 0.
REQ-034 Assert reset=0 while in REQ with Count_o=3 -> after that edge ReqW_o=0, Count_o=0, state IDLE, Ready_o=1.
REQ-035 Random Valid_i/Data_i against a random-latency four-phase ack model for 50000 cycles -> words at the bridge exactly match accepted words in order, and Data_o never changes while ReqW_o=1.
